// File: rtl/plab4_net_router_input_ctrl_sep_if.sv
// Bundle of handshake and request/grant signals for one router input
// controller.
//   master : the input controller (accepts flits, raises requests)
//   slave  : the surrounding fabric (offers flits, returns grants)
interface plab4_net_router_input_ctrl_sep_if #(
   parameter int p_msg_nbits = 44
);
   logic                   in_val;
   logic                   in_rdy;
   logic [p_msg_nbits-1:0] in_msg;
   logic                   in_domain;
   logic                   reqs_p0;
   logic                   reqs_p1;
   logic                   reqs_p2;
   logic                   grants_p0;
   logic                   grants_p1;
   logic                   grants_p2;
   logic                   reqs_domain;
   logic [p_msg_nbits-1:0] out_msg;

   modport master (
      input  in_val, in_msg, in_domain, grants_p0, grants_p1, grants_p2,
      output in_rdy, reqs_p0, reqs_p1, reqs_p2, reqs_domain, out_msg
   );

   modport slave (
      output in_val, in_msg, in_domain, grants_p0, grants_p1, grants_p2,
      input  in_rdy, reqs_p0, reqs_p1, reqs_p2, reqs_domain, out_msg
   );
endinterface

// File: rtl/plab4_net_router_input_ctrl_sep.sv
// Router input controller: circular flit buffer with per-flit security
// domain, ring route computation for the head flit, and separate one-hot
// request wires toward the three output controllers (p0 = previous router,
// p1 = terminal, p2 = next router). The head is dequeued when the grant on
// the requested port returns.
// Optional feature: define PLAB4_NET_ROUTER_INPUT_CTRL_BYPASS_EN to let a
// flit arriving at an empty buffer request in the same cycle and, if
// granted, skip the buffer entirely.
module plab4_net_router_input_ctrl_sep #(
   parameter int p_router_id   = 0,
   parameter int p_num_routers = 4,
   parameter int p_msg_nbits   = 44,
   parameter int p_dest_nbits  = 2,
   parameter int p_num_entries = 2
) (
   input  logic clk,
   input  logic reset,
   plab4_net_router_input_ctrl_sep_if.master io
);

   localparam int c_ptr_nbits = $clog2(p_num_entries);
   localparam int c_cnt_nbits = c_ptr_nbits + 1;
   localparam logic [c_cnt_nbits-1:0]  c_full = c_cnt_nbits'(p_num_entries);
   localparam logic [p_dest_nbits-1:0] c_id   = p_dest_nbits'(p_router_id);
   localparam logic [p_dest_nbits:0]   c_half = (p_dest_nbits+1)'(p_num_routers / 2);

   typedef enum logic [1:0] { ROUTE_P0, ROUTE_P1, ROUTE_P2 } route_e;

   // Each entry is {domain, msg}
   typedef logic [p_msg_nbits:0] entry_t;

   entry_t                 entries_q [p_num_entries];
   entry_t                 entries_d [p_num_entries];
   logic [c_ptr_nbits-1:0] head_q, head_d;
   logic [c_ptr_nbits-1:0] tail_q, tail_d;
   logic [c_cnt_nbits-1:0] count_q, count_d;

   logic                    empty;
   logic                    req_active;
   entry_t                  sel_entry;
   logic [p_dest_nbits-1:0] dest;
   logic [p_dest_nbits-1:0] fwd;
   route_e                  route;
   logic                    granted;
   logic                    enq;
   logic                    deq;

   // Pick the flit that currently requests: buffer head, or the incoming flit on bypass
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      empty      = (count_q == '0);
      sel_entry  = entries_q[head_q];
      req_active = !empty;
`ifdef PLAB4_NET_ROUTER_INPUT_CTRL_BYPASS_EN
      if (empty && io.in_val) begin
         sel_entry  = {io.in_domain, io.in_msg};
         req_active = 1'b1;
      end
`endif
   end

   // Ring routing: distance forward modulo ring size, ties at half go forward
   always_comb begin
      dest  = sel_entry[p_msg_nbits-1 -: p_dest_nbits];
      fwd   = dest - c_id;
      route = ROUTE_P0;
      if (fwd == '0)
         route = ROUTE_P1;
      else if ({1'b0, fwd} <= c_half)
         route = ROUTE_P2;
   end

   // Request outputs and the head-side view for the crossbar
   always_comb begin
      io.reqs_p0     = req_active && (route == ROUTE_P0);
      io.reqs_p1     = req_active && (route == ROUTE_P1);
      io.reqs_p2     = req_active && (route == ROUTE_P2);
      io.reqs_domain = req_active ? sel_entry[p_msg_nbits] : 1'b0;
      io.out_msg     = req_active ? sel_entry[p_msg_nbits-1:0] : '0;
      io.in_rdy      = (count_q != c_full);
   end

   // Handshake decisions and next-state for pointers, count and storage
   always_comb begin
      granted = (io.reqs_p0 && io.grants_p0) ||
                (io.reqs_p1 && io.grants_p1) ||
                (io.reqs_p2 && io.grants_p2);
      // A grant only dequeues a buffered head; a granted bypass flit is simply consumed
      deq     = granted && !empty;
      enq     = io.in_val && io.in_rdy && !(granted && empty);

      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      if (enq) begin
         entries_d[tail_q] = {io.in_domain, io.in_msg};
         tail_d            = tail_q + 1'b1;
      end
      if (deq)
         head_d = head_q + 1'b1;
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state: reset empties the buffer and ignores incoming flits
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Flit storage
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; stale entries are never visible because count gates every read.
      entries_q <= entries_d;
   end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_sep.sv
// Self-checking bench for plab4_net_router_input_ctrl_sep (router id 1,
// ring of 4, depth 2). A queue-based reference model tracks the buffered
// flits; a monitor compares the DUT outputs against the model every cycle.
module tb_plab4_net_router_input_ctrl_sep;

   localparam int ID    = 1;
   localparam int N     = 4;
   localparam int MSGW  = 44;
   localparam int DW    = 2;
   localparam int DEPTH = 2;

   typedef struct {
      logic [MSGW-1:0] msg;
      logic            dom;
      int              port;
   } flit_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   started  = 1'b0;
   flit_t sb [$];

   plab4_net_router_input_ctrl_sep_if #(.p_msg_nbits(MSGW)) io ();

   plab4_net_router_input_ctrl_sep #(
      .p_router_id   (ID),
      .p_num_routers (N),
      .p_msg_nbits   (MSGW),
      .p_dest_nbits  (DW),
      .p_num_entries (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Route from the ring rules: forward distance modulo the ring size
   function automatic int route_of(logic [MSGW-1:0] m);
      int d, fwd;
      d   = int'(m[MSGW-1 -: DW]);
      fwd = (d - ID + N) % N;
      if (fwd == 0)       return 1;
      else if (fwd <= N/2) return 2;
      else                return 0;
   endfunction

   function automatic logic [MSGW-1:0] mk_msg(int dest);
      logic [63:0]     r;
      logic [MSGW-1:0] m;
      r = {$urandom, $urandom};
      m = r[MSGW-1:0];
      m[MSGW-1 -: DW] = DW'(dest);
      return m;
   endfunction

   // Grant vector {p2,p1,p0} aimed at whatever the model says is requesting
   function automatic logic [2:0] tied();
      if (sb.size() == 0) return 3'b000;
      return 3'(1 << sb[0].port);
   endfunction

   // Reference model update on each rising edge
   always @(posedge clk) begin
      logic [2:0] g;
      bit         accept, consumed;
      flit_t      f;
      g = {io.grants_p2, io.grants_p1, io.grants_p0};
      if (reset) begin
         sb.delete();
         started <= 1'b1;
      end else if (started) begin
         accept   = io.in_val && (sb.size() < DEPTH);
         consumed = 1'b0;
         f.msg  = io.in_msg;
         f.dom  = io.in_domain;
         f.port = route_of(io.in_msg);
`ifdef PLAB4_NET_ROUTER_INPUT_CTRL_BYPASS_EN
         if (sb.size() == 0 && io.in_val && g[f.port]) consumed = 1'b1;
`endif
         if (sb.size() > 0 && g[sb[0].port]) void'(sb.pop_front());
         if (accept && !consumed) sb.push_back(f);
      end
   end

   // Monitor: compare DUT outputs to the model away from the active edge
   always @(negedge clk) begin
      bit         have;
      flit_t      e;
      logic [2:0] exp_reqs;
      if (started) begin
         have = 1'b0;
         if (sb.size() > 0) begin
            have = 1'b1;
            e    = sb[0];
         end
`ifdef PLAB4_NET_ROUTER_INPUT_CTRL_BYPASS_EN
         else if (io.in_val) begin
            have   = 1'b1;
            e.msg  = io.in_msg;
            e.dom  = io.in_domain;
            e.port = route_of(io.in_msg);
         end
`endif
         exp_reqs = have ? 3'(1 << e.port) : 3'b000;
         check("in_rdy", 64'(io.in_rdy), 64'(sb.size() < DEPTH));
         check("reqs", 64'({io.reqs_p2, io.reqs_p1, io.reqs_p0}), 64'(exp_reqs));
         check("reqs_domain", 64'(io.reqs_domain), have ? 64'(e.dom) : 64'd0);
         check("out_msg", 64'(io.out_msg), have ? 64'(e.msg) : 64'd0);
      end
   end

   task automatic step(logic val, int dest, logic dom, logic [2:0] g);
      io.in_val    = val;
      io.in_msg    = mk_msg(dest);
      io.in_domain = dom;
      {io.grants_p2, io.grants_p1, io.grants_p0} = g;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 0, 1'b0, tied());
   endtask

   int dests [4] = '{1, 2, 3, 0};
   logic doms [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   int exp_ports [4] = '{1, 2, 2, 0};

   initial begin
      reset        = 1'b1;
      io.in_val    = 1'b0;
      io.in_msg    = '0;
      io.in_domain = 1'b0;
      {io.grants_p2, io.grants_p1, io.grants_p0} = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0, 3'b000);

      // Route table for router 1: independent spot-check of the model's routing rule
      for (int i = 0; i < 4; i++)
         check("route_table", 64'(route_of(mk_msg(dests[i]))), 64'(exp_ports[i]));

      // Directed routes with tied grants; each flit requests the cycle after enqueue
      for (int i = 0; i < 4; i++) begin
         step(1'b1, dests[i], doms[i], tied());
         step(1'b0, 0, 1'b0, tied());
      end
      drain(2);

      // Fill with grants low: third flit refused, then one grant frees a slot
      for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(0, N-1), 1'($urandom), 3'b000);
      step(1'b0, 0, 1'b0, tied());
      step(1'b0, 0, 1'b0, 3'b000);
      drain(3);

      // Head routed to p2; grants on p0/p1 are ignored, then p2 dequeues
      step(1'b1, 2, 1'b1, 3'b000);
      step(1'b0, 0, 1'b0, 3'b011);
      step(1'b0, 0, 1'b0, 3'b011);
      step(1'b0, 0, 1'b0, 3'b100);
      drain(2);

      // One flit resident; enqueue and grant together for many cycles (pointer wrap)
      step(1'b1, $urandom_range(0, N-1), 1'($urandom), 3'b000);
      for (int i = 0; i < 12; i++) step(1'b1, $urandom_range(0, N-1), 1'($urandom), tied());
      drain(3);

      // Random traffic with a mix of tied and arbitrary grants
      for (int i = 0; i < 400; i++)
         step(1'($urandom), $urandom_range(0, N-1), 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 3'($urandom) : tied());
      drain(3);

      // Reset with two flits buffered; in_val during reset is ignored
      step(1'b1, 3, 1'b1, 3'b000);
      step(1'b1, 2, 1'b0, 3'b000);
      reset = 1'b1;
      step(1'b1, 1, 1'b1, 3'b000);
      reset = 1'b0;
      step(1'b0, 0, 1'b0, 3'b000);
      step(1'b0, 0, 1'b0, 3'b000);

`ifdef PLAB4_NET_ROUTER_INPUT_CTRL_BYPASS_EN
      // Bypass: empty buffer, flit to own id granted in the same cycle
      step(1'b1, ID, 1'b1, 3'b010);
      step(1'b0, 0, 1'b0, 3'b000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/plab4_net_router_input_ctrl_sep.md
# plab4_net_router_input_ctrl_sep

Input-side controller for one router port in the ring network. It buffers incoming flits together with their 1-bit security domain and computes the route for the head flit. It drives separate one-hot request wires to the three output controllers and dequeues the head when the matching grant returns. It is the requester end of the separate req/grant interface whose grant end is the router output controller.

## Interface
Parameters:
- p_router_id, 0, this router's index in the ring.
- p_num_routers, 4, ring size; power of two, ≥2.
- p_msg_nbits, 44, flit width.
- p_dest_nbits, 2, destination field width, equal to clog2(p_num_routers); the field is in_msg[p_msg_nbits-1 -: p_dest_nbits].
- p_num_entries, 2, buffer depth; power of two, ≥2.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- in_val, input, 1, incoming flit valid.
- in_rdy, output, 1, buffer can accept a flit.
- in_msg, input, p_msg_nbits, incoming flit.
- in_domain, input, 1, security domain of the incoming flit.
- reqs_p0, reqs_p1, reqs_p2, output, 1 each, head-flit request to output port 0 (previous router), 1 (terminal), 2 (next router).
- grants_p0, grants_p1, grants_p2, input, 1 each, grants from the output controllers.
- reqs_domain, output, 1, domain of the head flit; 0 when no request is pending.
- out_msg, output, p_msg_nbits, head flit to the crossbar; 0 when no request is pending.

## Operation
- Circular buffer of p_num_entries entries. Each entry is {domain, msg}. State: head pointer, tail pointer and an occupancy count of width clog2(p_num_entries)+1.
- Enqueue when in_val && in_rdy. in_rdy = (count != p_num_entries).
- No pipelined full: in_rdy stays 0 while the buffer is full, even if a dequeue happens in the same cycle.
- Route computation on the head destination d:
  - fwd = (d − p_router_id) mod p_num_routers, computed in p_dest_nbits bits with natural wrap.
  - fwd == 0 → port 1.
  - 0 < fwd ≤ p_num_routers/2 → port 2. A tie at exactly half goes to port 2.
  - Otherwise → port 0.
- When the buffer is non-empty, exactly one of reqs_p0/p1/p2 is high, selected by the route. When empty, all three are low.
- Dequeue when the grant on the currently requested port is high. Grants on non-requested ports are ignored.
- Multiple grants asserted together: only the requested port counts.
- Simultaneous enqueue and dequeue: count is unchanged, both pointers advance.
- Pointers wrap modulo p_num_entries.
- reqs, reqs_domain and out_msg are driven combinationally from the head entry.
- Reset mid-operation empties the buffer; buffered flits are discarded.

## Timing
- Reset values, effective the cycle after reset is sampled high:
  - count = 0, head = 0, tail = 0.
  - in_rdy = 1.
  - reqs_p0/p1/p2 = 0, reqs_domain = 0, out_msg = 0.
- While reset is high, in_val is ignored.
- Latency: a flit enqueued at edge N requests in cycle N+1. Minimum one cycle in buffer (bypass disabled).
- Grant-to-dequeue: a grant sampled at edge N removes the head. The next entry, if any, requests in cycle N+1 with no bubble.
- A request stays high with a stable route, domain and message until it is granted.
- Throughput: one flit per cycle in steady state when grants are continuous and p_num_entries ≥ 2.

## Configuration
- PLAB4_NET_ROUTER_INPUT_CTRL_BYPASS_EN
- Defined: when the buffer is empty and in_val is high:
  - The request, reqs_domain and out_msg are computed directly from in_msg/in_domain in the same cycle.
  - If the matching grant arrives that cycle, the flit is consumed and not enqueued.
  - Otherwise it is enqueued normally.
  - Zero-cycle latency; in_rdy is unchanged.
- Undefined: the bypass path does not exist; behaviour is exactly as in Timing.

## Test plan
- Reset, then idle: reqs all 0, in_rdy = 1, reqs_domain = 0, out_msg = 0 for 5 cycles.
- p_router_id = 1, N = 4, grants tied to the requested port. Inject dest 1, 2, 3, 0 with domains 0, 1, 0, 1. Required requests: p1, p2, p2 (tie), p0. reqs_domain tracks each flit's domain; each flit requests one cycle after enqueue (bypass off).
- Hold all grants low and inject 3 flits: in_rdy falls after 2 accepted. Then assert the matching grant for 1 cycle: one dequeue, and in_rdy = 1 the next cycle.
- Head routed to p2; assert grants_p0 and grants_p1 only: no dequeue and the head holds. Then grants_p2 = 1 → dequeue.
- Buffer holding 1 flit: enqueue and grant in the same cycle; count stays 1 and the new flit requests next cycle. Cycle ≥8 flits to check pointer wrap and that order is preserved.
- Reset asserted with 2 flits buffered: next cycle reqs = 0 and in_rdy = 1. With bypass on: empty buffer, in_val with dest = own id and grants_p1 = 1 in the same cycle → reqs_p1 = 1 that cycle and the buffer stays empty.
